// File: rtl/sci_pkg.sv
// Shared constants and state type for the uart host sequencer.
package sci_pkg;

    // uart register addresses
    localparam logic [1:0] SCI_ADDR_DATA = 2'b00;
    localparam logic [1:0] SCI_ADDR_STAT = 2'b01;
    localparam logic [1:0] SCI_ADDR_CTRL = 2'b11;

    // status register bit positions
    localparam int unsigned TDRE = 7;
    localparam int unsigned RDRF = 6;
    localparam int unsigned OE   = 0;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        POLL,
        RXRD,
        TXWR
    } state_t;

endpackage

// File: rtl/sci_byte_fifo.sv
// 8-bit synchronous FIFO, DEPTH a power of 2 (>=2), async active-low reset.
// Push while full is accepted only together with a pop.
module sci_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sci_host_seq.sv
// Bus-master sequencer between byte streams and the uart register interface.
// Optional build macro SCI_IRQ_POLL_EN: IDLE waits for sciirq (or pending tx
// bytes) before polling status.
module sci_host_seq
    import sci_pkg::*;
#(
    parameter int unsigned TX_DEPTH  = 4,
    parameter logic [7:0]  CTRL_INIT = 8'h40
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       oe_err,
    output logic       scisel,
    output logic       rw,
    output logic [1:0] addr,
    inout  wire  [7:0] dbus,
    input  logic       sciirq
);

    state_t     state;
    state_t     state_nx;
    logic       scisel_nx;
    logic       rw_nx;
    logic [1:0] addr_nx;
    logic [7:0] wdata;
    logic [7:0] wdata_nx;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       rx_free;
    logic       poll_go;

    assign tx_ready = !fifo_full && (state != INIT);
    assign rx_free  = !rx_valid || rx_ready;
    assign dbus     = (scisel && rw) ? wdata : 'z;

`ifdef SCI_IRQ_POLL_EN
    assign poll_go = sciirq || !fifo_empty;
`else
    logic unused_irq;
    assign unused_irq = sciirq;
    assign poll_go    = 1'b1;
`endif

    sci_byte_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (tx_valid && tx_ready),
        .din   (tx_data),
        .pop   (state == TXWR),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State and registered bus outputs; bus signals are set up one cycle ahead.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state  <= INIT;
            scisel <= 1'b0;
            rw     <= 1'b0;
            addr   <= SCI_ADDR_DATA;
            wdata  <= '0;
        end else begin
            state  <= state_nx;
            scisel <= scisel_nx;
            rw     <= rw_nx;
            addr   <= addr_nx;
            wdata  <= wdata_nx;
        end
    end

    // Next state and next bus access; POLL decides on the status byte on dbus.
    // INIT spends one set-up cycle (scisel low) before its write cycle.
    always_comb begin
        state_nx  = state;
        scisel_nx = 1'b0;
        rw_nx     = 1'b0;
        addr_nx   = SCI_ADDR_DATA;
        wdata_nx  = wdata;
        case (state)
            INIT: begin
                if (!scisel) begin
                    scisel_nx = 1'b1;
                    rw_nx     = 1'b1;
                    addr_nx   = SCI_ADDR_CTRL;
                    wdata_nx  = CTRL_INIT;
                end else begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                if (poll_go) begin
                    state_nx  = POLL;
                    scisel_nx = 1'b1;
                    addr_nx   = SCI_ADDR_STAT;
                end
            end
            POLL: begin
                if (dbus[RDRF] && rx_free) begin
                    state_nx  = RXRD;
                    scisel_nx = 1'b1;
                end else if (dbus[TDRE] && !fifo_empty) begin
                    state_nx  = TXWR;
                    scisel_nx = 1'b1;
                    rw_nx     = 1'b1;
                    wdata_nx  = fifo_head;
                end else begin
                    state_nx = IDLE;
                end
            end
            RXRD:    state_nx = IDLE;
            TXWR:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Receive slot: loaded at the end of the data read, emptied by the consumer.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (state == RXRD) begin
            rx_valid <= 1'b1;
            rx_data  <= dbus;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // Sticky overrun flag from any status read with OE set.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            oe_err <= 1'b0;
        end else if (state == POLL && dbus[OE]) begin
            oe_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sci_host_seq.sv
// Self-checking bench for sci_host_seq: directed bus scenarios plus a
// randomized loopback through a behavioural uart model.
module tb_sci_host_seq;

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       oe_err;
    logic       scisel;
    logic       rw;
    logic [1:0] addr;
    wire  [7:0] dbus;
    logic       sciirq = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // uart model controls (written by the stimulus block only)
    logic       loop_mode = 1'b0;
    logic       tdre_en = 1'b0;
    logic [7:0] st_reg = '0;
    logic [7:0] rd_reg = '0;

    // uart loopback state (written by the uart model block only)
    logic [7:0] uart_q[$];
    logic       q_ne = 1'b0;
    logic [7:0] q_head = '0;
    logic [7:0] bus_val;

    typedef struct {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
        int         cyc;
    } acc_t;
    acc_t acc_log[$];

    sci_host_seq #(.TX_DEPTH(4), .CTRL_INIT(8'h40)) dut (
        .clk      (clk),
        .rstb     (rstb),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .oe_err   (oe_err),
        .scisel   (scisel),
        .rw       (rw),
        .addr     (addr),
        .dbus     (dbus),
        .sciirq   (sciirq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read data returned by the uart model.
    always_comb begin
        bus_val = rd_reg;
        if (loop_mode)
            bus_val = (addr == 2'b01) ? {tdre_en, q_ne, 6'b0} : q_head;
        else if (addr == 2'b01)
            bus_val = st_reg;
    end

    assign dbus = (scisel && !rw) ? bus_val : 8'hzz;

    // Loopback uart: written bytes come back as received bytes, in order.
    always @(posedge clk) begin
        if (loop_mode && rstb && scisel && addr == 2'b00) begin
            if (rw) uart_q.push_back(dbus);
            else if (uart_q.size() != 0) void'(uart_q.pop_front());
        end
        q_ne   <= (uart_q.size() != 0);
        q_head <= (uart_q.size() != 0) ? uart_q[0] : 8'h00;
    end

    // Bus access log, one entry per cycle with scisel high.
    always @(negedge clk) begin
        if (rstb && scisel) acc_log.push_back('{rw, addr, dbus, cyc});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the first logged data-register access of the given direction.
    task automatic wait_data_acc(input logic want_rw, input string tag, output int idx);
        idx = -1;
        for (int n = 0; n < 30 && idx < 0; n++) begin
            for (int i = 0; i < acc_log.size(); i++)
                if (idx < 0 && acc_log[i].addr == 2'b00 && acc_log[i].rw == want_rw) idx = i;
            if (idx < 0) begin
                @(posedge clk);
                #1;
            end
        end
        chk({tag, "_found"}, idx >= 0, 1);
    endtask

    task automatic push_byte(input logic [7:0] b, input string tag);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        #1 chk({tag, "_ready"}, tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        int idx;
        int widx;
        int pcyc;
        int nreads;
        int wfound;
        int sent;
        int got;
        logic [7:0] exp_q[$];
        logic [7:0] b;

        // ---- Test 1: reset values and init sequence
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scisel", scisel, 0);
        chk("rst_rw", rw, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dbus_z", dbus === 8'hzz, 1);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_oe_err", oe_err, 0);
        @(negedge clk);
        acc_log.delete();
        rstb = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("init_count", acc_log.size() >= 3, 1);
        if (acc_log.size() >= 3) begin
            chk("init_rw", acc_log[0].rw, 1);
            chk("init_addr", acc_log[0].addr, 2'b11);
            chk("init_data", acc_log[0].data, 8'h40);
            chk("init_gap", acc_log[1].cyc - acc_log[0].cyc, 2);
            chk("poll1_read", {acc_log[1].rw, acc_log[1].addr}, 3'b001);
            chk("poll2_read", {acc_log[2].rw, acc_log[2].addr}, 3'b001);
            chk("poll_period", acc_log[2].cyc - acc_log[1].cyc, 2);
        end
        chk("init_tx_ready", tx_ready, 1);

        // ---- Test 2: transmit with TDRE set
        st_reg = 8'h80;
        acc_log.delete();
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h6B;
        pcyc = cyc;
        #1 chk("t2_ready", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        #1;
        wait_data_acc(1'b1, "t2_write", idx);
        if (idx >= 0) begin
            chk("t2_data", acc_log[idx].data, 8'h6B);
            chk("t2_latency", (acc_log[idx].cyc - pcyc) <= 3 && (acc_log[idx].cyc - pcyc) >= 1, 1);
        end
        chk("t2_ready_after", tx_ready, 1);

        // ---- Test 3: receive
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        acc_log.delete();
        rd_reg = 8'hA5;
        st_reg = 8'h40;
        wait_data_acc(1'b0, "t3_read", idx);
        st_reg = 8'h00;
        chk("t3_rx_valid", rx_valid, 1);
        chk("t3_rx_data", rx_data, 8'hA5);
        @(posedge clk);
        #1 chk("t3_consumed", rx_valid, 0);

        // ---- Test 4: RDRF and TDRE together, RX first
        push_byte(8'h11, "t4_push");
        @(posedge clk);
        #1;
        acc_log.delete();
        rd_reg = 8'h3C;
        st_reg = 8'hC0;
        wait_data_acc(1'b0, "t4_read", idx);
        st_reg = 8'h80;
        chk("t4_rx_data", rx_data, 8'h3C);
        wait_data_acc(1'b1, "t4_write", widx);
        if (idx >= 0 && widx >= 0) begin
            chk("t4_order", acc_log[widx].cyc - acc_log[idx].cyc, 3);
            chk("t4_wdata", acc_log[widx].data, 8'h11);
        end
        st_reg = 8'h00;

        // ---- Test 5: rx backpressure, overrun reported
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        acc_log.delete();
        rd_reg = 8'h5A;
        st_reg = 8'h40;
        wait_data_acc(1'b0, "t5_first_read", idx);
        push_byte(8'h22, "t5_push");
        chk("t5_oe_before", oe_err, 0);
        @(posedge clk);
        #1;
        acc_log.delete();
        st_reg = 8'hC1;
        repeat (8) @(posedge clk);
        #1;
        nreads = 0;
        wfound = 0;
        foreach (acc_log[i]) begin
            if (acc_log[i].addr == 2'b00 && !acc_log[i].rw) nreads++;
            if (acc_log[i].addr == 2'b00 && acc_log[i].rw && acc_log[i].data == 8'h22) wfound++;
        end
        chk("t5_no_read", nreads, 0);
        chk("t5_tx_taken", wfound, 1);
        chk("t5_oe_err", oe_err, 1);
        chk("t5_rx_held", {rx_valid, rx_data}, {1'b1, 8'h5A});
        st_reg = 8'h00;
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        #1 chk("t5_drained", rx_valid, 0);

        // ---- Test 6: loopback, fill FIFO, random traffic
        loop_mode = 1'b1;
        tdre_en   = 1'b0;
        rx_ready  = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            push_byte(b, "t6_fill");
            exp_q.push_back(b);
        end
        repeat (3) @(posedge clk);
        #1 chk("t6_full_ready", tx_ready, 0);
        sent = 4;
        got = 0;
        for (int n = 0; n < 800 && got < 20; n++) begin
            @(negedge clk);
            tdre_en  = ($urandom_range(0, 3) != 0);
            rx_ready = $urandom_range(0, 1) != 0;
            tx_valid = (sent < 20) && ($urandom_range(0, 1) != 0);
            tx_data  = 8'($urandom);
            #1;
            if (tx_valid && tx_ready) begin
                exp_q.push_back(tx_data);
                sent++;
            end
            if (rx_valid && rx_ready) begin
                got++;
                if (exp_q.size() == 0) chk("t6_extra_byte", 1, 0);
                else chk("t6_loop_data", rx_data, exp_q.pop_front());
            end
        end
        tx_valid = 1'b0;
        chk("t6_loop_count", got, 20);

        // reset asserted in the middle of a data write
        rx_ready = 1'b1;
        tdre_en  = 1'b0;
        push_byte(8'hE7, "t6_last_push");
        tdre_en = 1'b1;
        wfound = 0;
        for (int n = 0; n < 30 && wfound == 0; n++) begin
            @(negedge clk);
            if (scisel && rw && addr == 2'b00) wfound = 1;
        end
        chk("t6_txwr_seen", wfound, 1);
        #2 rstb = 1'b0;
        #1;
        chk("mid_scisel", scisel, 0);
        chk("mid_dbus_z", dbus === 8'hzz, 1);
        chk("mid_rw_addr", {rw, addr}, 3'b000);
        chk("mid_tx_ready", tx_ready, 0);
        chk("mid_rx", {rx_valid, rx_data}, 9'h000);
        chk("mid_oe_err", oe_err, 0);
        @(posedge clk);
        #1 chk("mid_no_partial", uart_q.size(), 0);
        @(negedge clk);
        acc_log.delete();
        rstb = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        wfound = 0;
        foreach (acc_log[i])
            if (acc_log[i].addr == 2'b00 && acc_log[i].rw) wfound++;
        chk("mid_fifo_emptied", wfound, 0);
        if (acc_log.size() > 0) chk("mid_reinit", {acc_log[0].rw, acc_log[0].addr, acc_log[0].data}, {1'b1, 2'b11, 8'h40});
        else chk("mid_reinit_seen", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
